// File: rtl/stroke_pkg.sv
// Shared definitions for the stroke command path: word widths, FIFO depth
// and the layout of one stroke command as seen by parser and executor.
package stroke_pkg;

   localparam int CMD_W   = 32;
   localparam int FIFO_AW = 4;

   typedef enum logic [7:0] {
      OP_NOP      = 8'h00,
      OP_MOVE     = 8'h01,
      OP_LINE     = 8'h02,
      OP_PEN_UP   = 8'h03,
      OP_PEN_DOWN = 8'h04
   } stroke_op_e;

   // opcode in the top byte, then 12-bit X and 12-bit Y coordinates
   typedef struct packed {
      stroke_op_e  opcode;
      logic [11:0] x;
      logic [11:0] y;
   } stroke_cmd_t;

   function automatic stroke_cmd_t unpack_cmd(input logic [CMD_W-1:0] word);
      return stroke_cmd_t'(word);
   endfunction

endpackage

// File: rtl/stroke_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A same-address write and read in one cycle returns the old word.
module stroke_fifo_ram #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // storage array, deliberately without reset
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // registered read port; holds its value when no read is issued
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/stroke_cmd_fifo.sv
// Command FIFO between the host command parser and the stroke executor.
// All flags are registered and derived from the next-state count, so they
// change together with count and have no combinational path from wr_en/rd_en.
module stroke_cmd_fifo
   import stroke_pkg::*;
#(
   parameter int DATA_W    = CMD_W,
   parameter int ADDR_W    = FIFO_AW,
   parameter int AFULL_LVL = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   input  logic              clr_ovf,
   output logic              alarm
);

   localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(1 << ADDR_W);
   localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_LVL);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              afull_q, afull_d;
   logic              ovf_q, ovf_d;
   logic              alarm_q, alarm_d;
   logic              rd_valid_q;
   logic              rd_acc, wr_acc;

   // accept decisions; a read frees the slot a same-cycle write fills when full
   always_comb begin
      rd_acc = rd_en & ~empty_q;
      wr_acc = wr_en & (~full_q | rd_acc);
   end

   // next-state pointers, occupancy, flags and sticky overflow
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);

      count_d = count_q + {{ADDR_W{1'b0}}, wr_acc} - {{ADDR_W{1'b0}}, rd_acc};
      full_d  = (count_d == FULL_CNT);
      empty_d = (count_d == '0);
      afull_d = (count_d >= AFULL_CNT);

      ovf_d = ovf_q;
      if (wr_en && !wr_acc) ovf_d = 1'b1;
      else if (clr_ovf)     ovf_d = 1'b0;

      alarm_d = full_d | ovf_d;
   end

   // state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         afull_q    <= 1'b0;
         ovf_q      <= 1'b0;
         alarm_q    <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         afull_q    <= afull_d;
         ovf_q      <= ovf_d;
         alarm_q    <= alarm_d;
         rd_valid_q <= rd_acc;
      end
   end

   stroke_fifo_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (wr_acc),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_data),
      .re_i    (rd_acc),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_data)
   );

   assign rd_valid    = rd_valid_q;
   assign full        = full_q;
   assign empty       = empty_q;
   assign almost_full = afull_q;
   assign count       = count_q;
   assign overflow    = ovf_q;
   assign alarm       = alarm_q;

endmodule

// File: tb/tb_stroke_cmd_fifo.sv
// Bench for stroke_cmd_fifo: directed stimulus with a reference queue model;
// expected read words go into a scoreboard that a negedge monitor checks.
module tb_stroke_cmd_fifo;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] wr_data = '0;
   logic        rd_en = 1'b0;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        full;
   logic        empty;
   logic        almost_full;
   logic [4:0]  count;
   logic        overflow;
   logic        clr_ovf = 1'b0;
   logic        alarm;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] model_q [$];
   logic [31:0] exp_q [$];
   bit          m_ovf = 0;

   stroke_cmd_fifo #(.DATA_W(32), .ADDR_W(4), .AFULL_LVL(14)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .count       (count),
      .overflow    (overflow),
      .clr_ovf     (clr_ovf),
      .alarm       (alarm)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // one clock of stimulus; reference model updated at the edge, flags checked 1ns after
   task automatic step(input bit w, input logic [31:0] d, input bit r, input bit c);
      bit ra, wa;
      int sz;
      wr_en   = w;
      wr_data = d;
      rd_en   = r;
      clr_ovf = c;
      ra = r && (model_q.size() > 0);
      wa = w && ((model_q.size() < 16) || ra);
      @(posedge clk);
      if (ra) exp_q.push_back(model_q.pop_front());
      if (wa) model_q.push_back(d);
      if (w && !wa) m_ovf = 1;
      else if (c)   m_ovf = 0;
      #1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      clr_ovf = 1'b0;
      sz = model_q.size();
      chk("count",       32'(count),       32'(sz));
      chk("full",        32'(full),        32'(sz == 16));
      chk("empty",       32'(empty),       32'(sz == 0));
      chk("almost_full", 32'(almost_full), 32'(sz >= 14));
      chk("overflow",    32'(overflow),    32'(m_ovf));
      chk("alarm",       32'(alarm),       32'((sz == 16) || m_ovf));
      chk("rd_valid",    32'(rd_valid),    32'(ra));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, 0, 0);
   endtask

   task automatic sb_drained(input string name);
      idle(2);
      chk(name, 32'(exp_q.size()), 32'd0);
   endtask

   // monitor: every rd_valid strobe must match the oldest expected word
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && rd_valid) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL rd_unexpected: got %h, want no strobe", rd_data);
            end else begin
               chk("rd_data", rd_data, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rd_data", rd_data, 32'h0);
      chk("rst_empty", 32'(empty), 32'd1);
      rst_n = 1'b1;

      // idle after reset
      idle(5);
      chk("idle_empty", 32'(empty), 32'd1);
      chk("idle_alarm", 32'(alarm), 32'd0);

      // fill 16, almost_full appears once count reaches 14
      for (int i = 0; i < 16; i++) begin
         step(1, 32'hA000_0000 + 32'(i), 0, 0);
         if (i == 12) chk("afull_at13", 32'(almost_full), 32'd0);
         if (i == 13) chk("afull_at14", 32'(almost_full), 32'd1);
      end
      chk("fill_count", 32'(count), 32'd16);
      chk("fill_alarm", 32'(alarm), 32'd1);
      for (int i = 0; i < 16; i++) step(0, '0, 1, 0);
      sb_drained("drain1_done");
      chk("drain1_empty", 32'(empty), 32'd1);
      chk("drain1_alarm", 32'(alarm), 32'd0);

      // overflow: dropped word never appears, sticky until cleared
      for (int i = 0; i < 16; i++) step(1, 32'h1000_0000 + 32'(i), 0, 0);
      step(1, 32'hDEAD_BEEF, 0, 0);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(count), 32'd16);
      for (int i = 0; i < 16; i++) step(0, '0, 1, 0);
      sb_drained("drain2_done");
      chk("ovf_sticky", 32'(overflow), 32'd1);
      chk("ovf_alarm_held", 32'(alarm), 32'd1);
      step(0, '0, 0, 1);
      chk("ovf_cleared", 32'(overflow), 32'd0);
      chk("alarm_cleared", 32'(alarm), 32'd0);

      // simultaneous write/read while full
      for (int i = 0; i < 16; i++) step(1, 32'h2000_0000 + 32'(i), 0, 0);
      for (int i = 0; i < 8; i++) step(1, 32'h0000_00B0 + 32'(i), 1, 0);
      chk("wr_rd_full_count", 32'(count), 32'd16);
      chk("wr_rd_full_ovf", 32'(overflow), 32'd0);
      for (int i = 0; i < 16; i++) step(0, '0, 1, 0);
      sb_drained("drain3_done");

      // simultaneous write/read while empty: no read-through
      step(1, 32'h55, 1, 0);
      chk("empty_wr_rd_valid", 32'(rd_valid), 32'd0);
      chk("empty_wr_rd_count", 32'(count), 32'd1);
      step(0, '0, 1, 0);
      chk("read_55", rd_data, 32'h55);
      // rejected read keeps rd_data
      step(0, '0, 1, 0);
      chk("rej_rd_hold", rd_data, 32'h55);
      sb_drained("drain4_done");

      // interleaved traffic wrapping the pointers, then async reset mid-burst
      for (int i = 0; i < 40; i++) step(1, 32'hC000_0000 + 32'(i), (i % 3) != 0, 0);
      step(0, '0, 0, 0);
      step(1, 32'hC000_00FF, 1, 0);
      #1;
      rst_n = 1'b0;
      #1;
      model_q.delete();
      exp_q.delete();
      m_ovf = 0;
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_empty", 32'(empty), 32'd1);
      chk("arst_full", 32'(full), 32'd0);
      chk("arst_afull", 32'(almost_full), 32'd0);
      chk("arst_ovf", 32'(overflow), 32'd0);
      chk("arst_alarm", 32'(alarm), 32'd0);
      chk("arst_rd_valid", 32'(rd_valid), 32'd0);
      chk("arst_rd_data", rd_data, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1, 32'h1234, 0, 0);
      step(0, '0, 1, 0);
      chk("post_rst_read", rd_data, 32'h1234);
      sb_drained("drain5_done");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
